// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: op encoding, flag bit
// positions and the packed FIFO entry layout.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] result;
    } entry_t;

    // Ops whose carry input is meaningful: add/sub borrow or last shifted-out bit.
    function automatic logic op_has_carry(input alu_op_t op);
        logic has_carry;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA: has_carry = 1'b1;
            default:                                     has_carry = 1'b0;
        endcase
        return has_carry;
    endfunction

    function automatic logic op_has_ovf(input alu_op_t op);
        logic has_ovf;
        case (op)
            ALU_ADD, ALU_SUB: has_ovf = 1'b1;
            default:          has_ovf = 1'b0;
        endcase
        return has_ovf;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} derivation from the producing op and its raw result.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] result,
    input  logic        carry,
    input  logic        ovf,
    output logic [3:0]  flags
);

    alu_op_t op_s;

    assign op_s = alu_op_t'(op);

    // Unknown encodings fall through the helpers' defaults and get C=V=0.
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == 32'd0);
        flags[FLAG_C] = carry & op_has_carry(op_s);
        flags[FLAG_V] = ovf & op_has_ovf(op_s);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flag capture, 2-entry FIFO toward writeback,
// sticky overflow and a saturating retired-result counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_result,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [1:0]       FULL_CNT = 2'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    entry_t           mem_r [0:1];
    entry_t           mem_nxt_s [0:1];
    logic             rd_ptr_r, wr_ptr_r;
    logic             rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [1:0]       count_r, count_nxt_s;
    logic             in_ready_r, out_valid_r, sticky_r;
    logic [31:0]      out_result_r;
    logic [3:0]       out_flags_r;
    logic [CNT_W-1:0] retired_r, retired_nxt_s;
    logic             sticky_nxt_s;
    logic [3:0]       flags_s;
    logic             push_s, pop_s;
    entry_t           head_nxt_s;

    alu_flag_gen u_flag_gen (
        .op     (in_op),
        .result (in_result),
        .carry  (in_carry),
        .ovf    (in_ovf),
        .flags  (flags_s)
    );

    // Handshakes depend only on registered state, so out_ready never reaches in_ready.
    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next FIFO contents, pointers, count and the head that will be presented.
    always_comb begin
        mem_nxt_s    = mem_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_s) begin
            mem_nxt_s[wr_ptr_r] = '{flags: flags_s, result: in_result};
            wr_ptr_nxt_s        = ~wr_ptr_r;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = ~rd_ptr_r;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        if (count_nxt_s != 2'd0) begin
            head_nxt_s = mem_nxt_s[rd_ptr_nxt_s];
        end else begin
            head_nxt_s = '0;
        end
    end

    // Sticky overflow (set beats clear) and saturating retire counter.
    always_comb begin
        sticky_nxt_s  = sticky_r;
        retired_nxt_s = retired_r;
        if (push_s && flags_s[FLAG_V]) begin
            sticky_nxt_s = 1'b1;
        end else if (clr_sticky) begin
            sticky_nxt_s = 1'b0;
        end else begin
            sticky_nxt_s = sticky_r;
        end
        if (pop_s && (retired_r != CNT_MAX)) begin
            retired_nxt_s = retired_r + CNT_ONE;
        end else begin
            retired_nxt_s = retired_r;
        end
    end

    // State and output registers; reset discards queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0]     <= '0;
            mem_r[1]     <= '0;
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= 32'd0;
            out_flags_r  <= 4'd0;
            sticky_r     <= 1'b0;
            retired_r    <= '0;
        end else begin
            mem_r[0]     <= mem_nxt_s[0];
            mem_r[1]     <= mem_nxt_s[1];
            rd_ptr_r     <= rd_ptr_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            count_r      <= count_nxt_s;
            in_ready_r   <= (count_nxt_s != FULL_CNT);
            out_valid_r  <= (count_nxt_s != 2'd0);
            out_result_r <= head_nxt_s.result;
            out_flags_r  <= head_nxt_s.flags;
            sticky_r     <= sticky_nxt_s;
            retired_r    <= retired_nxt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_result  = out_result_r;
    assign out_flags   = out_flags_r;
    assign sticky_ovf  = sticky_r;
    assign retired_cnt = retired_r;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage for the 32-bit ALU. It sits directly downstream of the shift units (sll/srl/sra) and the other functional units, and consumes their raw 32-bit result together with the op that produced it. It derives zero/negative/carry/overflow flags, buffers results in a 2-entry FIFO with a valid/ready handshake toward writeback, and keeps a sticky overflow bit and a saturating retired-result counter.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; the only supported value is 2.
- CNT_W, 16, width of the retired-result counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the upstream unit presents a result.
- in_ready  out  1  the stage can accept a result this cycle.
- in_op  in  4  alu_op_t of the producing operation.
- in_result  in  32  raw result from the functional unit.
- in_carry  in  1  carry/borrow from ADD/SUB, or the last bit shifted out for SLL/SRL/SRA.
- in_ovf  in  1  signed overflow from ADD/SUB.
- out_valid  out  1  the FIFO head is valid.
- out_ready  in  1  writeback accepts the head.
- out_result  out  32  result at the FIFO head.
- out_flags  out  4  {N,Z,C,V} for the head.
- sticky_ovf  out  1  set by any accepted result whose V=1.
- clr_sticky  in  1  clears sticky_ovf.
- retired_cnt  out  CNT_W  number of results popped, saturating.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Flags are computed at push time and stored with the entry:
  - Z = (in_result == 0).
  - N = in_result[31].
  - C = in_carry for ADD, SUB, SLL, SRL and SRA; 0 for all other ops.
  - V = in_ovf for ADD and SUB; 0 for all other ops.
- Ops outside the enumerated set are stored unchanged with C=V=0 (no error).
- sticky_ovf: if clr_sticky and a V=1 push occur in the same cycle, the set wins.
- retired_cnt increments by 1 on each pop and holds at all-ones.
- FIFO uses two entries, a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
  - Pointers wrap 1 -> 0.
  - Push and pop in the same cycle leave count unchanged.
- out_result and out_flags hold their value while out_valid=1 and out_ready=0.
- out_result and out_flags are 0 when the FIFO is empty.

## Timing
- Reset values: out_valid=0, out_result=0, out_flags=0, sticky_ovf=0, retired_cnt=0, count=0, pointers=0. in_ready=1 in the first cycle after reset.
- in_ready = (count != 2). It is derived from registered state only, so there is no combinational path from out_ready.
- Latency: a result pushed at edge k appears on out_valid/out_result in the cycle following edge k.
- Throughput: 1 result per cycle while out_ready stays high.
- Full (count=2): in_ready=0 and no push occurs, even if a pop happens in that same cycle. in_ready rises the cycle after the pop.
- Empty: a pop is impossible (out_valid=0). A push into an empty FIFO becomes the head on the next cycle.
- Reset asserted mid-operation discards all entries on that edge. Reset takes priority over a simultaneous push or pop.
- sticky_ovf and retired_cnt update on the same edge as the triggering push or pop.

## Structure
- Package alu_pkg holds:
  - alu_op_t (4 bits): ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, SRA=9.
  - Flag bit-index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_flag_gen: combinational mapping of op, result, carry and ovf to the 4-bit flags.
- FIFO storage and control stay inline in alu_result_stage.

## Test plan
- Reset, then push SLL result 0x0000_0000 with carry=1 -> next cycle out_valid=1, out_result=0, out_flags=0b0110.
- Push ADD result 0x8000_0000 with ovf=1, hold out_ready=0 -> out_flags=0b1001; sticky_ovf=1; output stable for 5 cycles.
- Back-to-back pushes of 0x1, 0x2, 0x3 with out_ready=0 -> in_ready=0 after the 2nd push; 0x3 is held off; after one pop, in_ready=1 and ordering is 0x1, 0x2, 0x3.
- clr_sticky in the same cycle as a SUB push with ovf=1 -> sticky_ovf=1. A later clr_sticky with no overflow push -> sticky_ovf=0.
- AND result 0x5 with carry=1 and ovf=1 -> out_flags=0b0000; sticky_ovf unchanged.
- Assert rst with 2 entries queued -> next cycle out_valid=0, in_ready=1, retired_cnt=0; queued entries are never output.
